instruction_fetch: RTL and testbench

Front pipeline stage of the rv32i core. Owns the program counter and issues reads to the I-cache. Holds each returned word until the decode stage can accept it, and presents PC and instruction on the IF/ID register (`PC_out`, `instruction_out`), which feeds decode's `PC` and `data_` inputs. Handles taken-branch/jump redirects from execute, including a redirect that arrives while a cache read is still in flight.

---
 rtl/rv32i_types.sv | 18 +
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i core types: instruction-fetch FSM states, the canonical NOP and
// a PC increment helper.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  // Sequential PC step; wraps modulo 2^32
  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rv32i fetch stage: PC, I-cache request, hold buffer and redirect draining.
// Optional IF_PERF_EN adds saturating fetch/stall counters.
module instruction_fetch
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MA_stall,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_target,
  input  logic        icache_resp,
  input  logic [31:0] icache_rdata,
  output logic        icache_read,
  output logic [31:0] icache_address,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
`ifdef IF_PERF_EN
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_stall_count,
`endif
  output logic        IF_stall
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        accept;
  logic        redirect;
  logic [31:0] target;

  assign redirect = pc_redirect && !MA_stall;
  assign target   = redirect_target & 32'hFFFF_FFFC;

  assign icache_read     = (state_q == FETCH || state_q == DRAIN) && !rst;
  assign icache_address  = pc_q;
  assign IF_stall        = ((state_q == FETCH || state_q == DRAIN) && !icache_resp)
                           || (state_q == DRAIN);
  assign PC_out          = pc_out_q;
  assign instruction_out = instr_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    tgt_d    = tgt_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    accept   = 1'b0;
    if (redirect) begin
      pc_out_d = 32'h0;
      instr_d  = RV32I_NOP;
    end
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (icache_resp) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = DRAIN;
          end
        end else if (icache_resp) begin
          if (!MA_stall) begin
            pc_out_d = pc_q;
            instr_d  = icache_rdata;
            pc_d     = pc_next_seq(pc_q);
            accept   = 1'b1;
          end else begin
            hold_d  = icache_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!MA_stall) begin
          pc_out_d = pc_q;
          instr_d  = hold_q;
          pc_d     = pc_next_seq(pc_q);
          accept   = 1'b1;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        // A newer redirect replaces the pending target; the in-flight word is discarded.
        if (redirect) tgt_d = target;
        if (icache_resp) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      hold_q   <= 32'h0;
      tgt_q    <= 32'h0;
      pc_out_q <= 32'h0;
      instr_q  <= RV32I_NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      tgt_q    <= tgt_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (IF_stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a default-PC instance plus a wrap instance
// (RESET_PC = 0xFFFFFFFC) driven by the same stimulus.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        MA_stall;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic        icache_read, icache_read2;
  logic [31:0] icache_address, icache_address2;
  logic [31:0] PC_out, PC_out2;
  logic [31:0] instruction_out, instruction_out2;
  logic        IF_stall, IF_stall2;
`ifdef IF_PERF_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .MA_stall(MA_stall), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .icache_resp(icache_resp),
    .icache_rdata(icache_rdata), .icache_read(icache_read),
    .icache_address(icache_address), .PC_out(PC_out),
    .instruction_out(instruction_out),
`ifdef IF_PERF_EN
    .perf_fetch_count(pf1), .perf_stall_count(ps1),
`endif
    .IF_stall(IF_stall)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .MA_stall(MA_stall), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .icache_resp(icache_resp),
    .icache_rdata(icache_rdata), .icache_read(icache_read2),
    .icache_address(icache_address2), .PC_out(PC_out2),
    .instruction_out(instruction_out2),
`ifdef IF_PERF_EN
    .perf_fetch_count(pf2), .perf_stall_count(ps2),
`endif
    .IF_stall(IF_stall2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_pc"}, PC_out, pc);
    chk({tag, "_ins"}, instruction_out, ins);
  endtask

  initial begin
    rst = 1'b1; MA_stall = 1'b0; pc_redirect = 1'b0; redirect_target = 32'h0;
    icache_resp = 1'b0; icache_rdata = 32'h0;
    tick(); tick();
    chk("rst_read", {31'h0, icache_read}, 32'h0);
    chk("rst_addr", icache_address, 32'h60);
    ifid("rst_ifid", 32'h0, 32'h13);
    chk("rst_wrap_addr", icache_address2, 32'hFFFF_FFFC);

    // zero-wait fetch
    rst = 1'b0; icache_resp = 1'b1; icache_rdata = 32'h1; #1;
    chk("zw_read0", {31'h0, icache_read}, 32'h1);
    chk("zw_addr0", icache_address, 32'h60);
    chk("zw_stall0", {31'h0, IF_stall}, 32'h0);
    tick();
    ifid("zw_ifid0", 32'h60, 32'h1);
    chk("wrap_ifid_pc", PC_out2, 32'hFFFF_FFFC);
    chk("wrap_next_addr", icache_address2, 32'h0);
    icache_rdata = 32'h2; #1;
    chk("zw_addr1", icache_address, 32'h64);
    chk("zw_stall1", {31'h0, IF_stall}, 32'h0);
    tick();
    ifid("zw_ifid1", 32'h64, 32'h2);
    icache_rdata = 32'h3; #1;
    chk("zw_addr2", icache_address, 32'h68);
    tick();
    ifid("zw_ifid2", 32'h68, 32'h3);

    // three wait states at 0x6C
    icache_resp = 1'b0; icache_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_stall", {31'h0, IF_stall}, 32'h1);
      chk("ws_addr", icache_address, 32'h6C);
      tick();
      chk("ws_ins_hold", instruction_out, 32'h3);
    end
    icache_resp = 1'b1; icache_rdata = 32'hAAAA_0001; #1;
    chk("ws_resp_stall", {31'h0, IF_stall}, 32'h0);
    tick();
    ifid("ws_ifid", 32'h6C, 32'hAAAA_0001);

    // MA_stall for 4 cycles starting at the response
    MA_stall = 1'b1; icache_rdata = 32'hDEAD_BEEF; #1;
    tick();
    icache_resp = 1'b0; icache_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_read", {31'h0, icache_read}, 32'h0);
      ifid("hold_ifid", 32'h6C, 32'hAAAA_0001);
      tick();
    end
    MA_stall = 1'b0; #1;
    chk("hold_read_last", {31'h0, icache_read}, 32'h0);
    tick();
    ifid("hold_release", 32'h70, 32'hDEAD_BEEF);
    chk("hold_next_addr", icache_address, 32'h74);
    chk("hold_next_read", {31'h0, icache_read}, 32'h1);

    // redirect in the response cycle, low target bits ignored
    icache_resp = 1'b1; icache_rdata = 32'h0BAD_0BAD;
    pc_redirect = 1'b1; redirect_target = 32'h0000_0203;
    tick();
    ifid("rd_flush", 32'h0, 32'h13);
    chk("rd_addr", icache_address, 32'h200);
    pc_redirect = 1'b0; icache_rdata = 32'h11;
    tick();
    ifid("rd_first", 32'h200, 32'h11);
    chk("rd_addr2", icache_address, 32'h204);

    // redirect while the read at 0x204 still has 2 wait cycles
    icache_resp = 1'b0; pc_redirect = 1'b1; redirect_target = 32'h400;
    tick();
    pc_redirect = 1'b0;
    ifid("dr_flush", 32'h0, 32'h13);
    chk("dr_addr0", icache_address, 32'h204);
    chk("dr_read0", {31'h0, icache_read}, 32'h1);
    chk("dr_stall0", {31'h0, IF_stall}, 32'h1);
    tick();
    chk("dr_addr1", icache_address, 32'h204);
    icache_resp = 1'b1; icache_rdata = 32'hBAD0_BAD0; #1;
    chk("dr_stall_resp", {31'h0, IF_stall}, 32'h1);
    tick();
    chk("dr_addr_tgt", icache_address, 32'h400);
    ifid("dr_dropped", 32'h0, 32'h13);
    icache_rdata = 32'h22;
    tick();
    ifid("dr_first", 32'h400, 32'h22);

    // second redirect during DRAIN together with response: newest target wins
    icache_resp = 1'b0; pc_redirect = 1'b1; redirect_target = 32'h500;
    tick();
    icache_resp = 1'b1; redirect_target = 32'h600;
    tick();
    pc_redirect = 1'b0; icache_resp = 1'b0;
    chk("dr2_addr", icache_address, 32'h600);
    ifid("dr2_flush", 32'h0, 32'h13);

    // reset mid-operation
    rst = 1'b1; #1;
    chk("rst2_read", {31'h0, icache_read}, 32'h0);
    tick();
    chk("rst2_addr", icache_address, 32'h60);
    ifid("rst2_ifid", 32'h0, 32'h13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
